// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock qualifier releasing the fabric reset once lock is stable.
// Optional WAIT_LOCK timeout-and-retry enabled by defining PLL_RESET_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       force_relock,
  input  logic       clear_count,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count
);

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int BASE_MAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int TO_SIZE  = TIMEOUT_EN ? LOCK_TIMEOUT_CYCLES : 0;
  localparam int MAX_CYC  = (TO_SIZE > BASE_MAX) ? TO_SIZE : BASE_MAX;
  localparam int CW       = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    sync;
  logic          lk;
  logic          loss;

  assign lk    = sync[1];
  assign state = cur;

  // Counter only advances where it measures something, so it can never wrap
  // while parked in WAIT_LOCK or RUN.
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    loss    = 1'b0;
    if (force_relock) begin
      nxt = S_PLL_RST;
    end else begin
      case (cur)
        S_PLL_RST: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(PLL_RST_CYCLES - 1)) nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            nxt = S_STABLE;
          end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
          else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) nxt = S_PLL_RST;
          end
`endif
        end
        S_STABLE: begin
          cnt_nxt = cnt + CW'(1);
          if (!lk) nxt = S_WAIT_LOCK;
          else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) nxt = S_RUN;
        end
        S_RUN: begin
          if (!lk) begin
            nxt  = S_PLL_RST;
            loss = 1'b1;
          end
        end
        default: nxt = S_PLL_RST;
      endcase
    end
    if (force_relock || (nxt != cur)) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync            <= 2'b00;
      cur             <= S_PLL_RST;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      sync        <= {sync[0], locked_in};
      cur         <= nxt;
      cnt         <= cnt_nxt;
      pll_rst     <= (nxt == S_PLL_RST);
      sys_reset_n <= (nxt == S_RUN);
      ready       <= (nxt == S_RUN);
      if (clear_count)
        lock_loss_count <= loss ? 8'd1 : 8'd0;
      else if (loss && (lock_loss_count != 8'hFF))
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed and randomized checks of pll_reset_sequencer against a timing model.
module tb_pll_reset_sequencer;
  localparam int PR = 4;
  localparam int ST = 8;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       locked_in = 1'b0;
  logic       force_relock = 1'b0;
  logic       clear_count = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;

  int vectors = 0;
  int miscompares = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PR),
    .LOCK_STABLE_CYCLES(ST),
    .LOCK_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .locked_in(locked_in),
    .force_relock(force_relock),
    .clear_count(clear_count),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .ready(ready),
    .state(state),
    .lock_loss_count(lock_loss_count)
  );

  always #10 clk = ~clk;

  // Phase/age model: age is the number of cycles already spent in the phase,
  // lk is locked_in seen two samples late.
  int m_phase = 0;
  int m_age = 0;
  int m_count = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  bit m_lk;
  bit m_lost;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_age = 0; m_count = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_lk = m_s2; m_s2 = m_s1; m_s1 = locked_in; m_lost = 1'b0;
      if (force_relock) begin
        m_phase = 0; m_age = 0;
      end else if (m_phase == 0) begin
        m_age++;
        if (m_age == PR) begin m_phase = 1; m_age = 0; end
      end else if (m_phase == 1) begin
        if (m_lk) begin
          m_phase = 2; m_age = 0;
        end else begin
          m_age++;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
          if (m_age == TO) begin m_phase = 0; m_age = 0; end
`endif
        end
      end else if (m_phase == 2) begin
        if (!m_lk) begin
          m_phase = 1; m_age = 0;
        end else begin
          m_age++;
          if (m_age == ST) begin m_phase = 3; m_age = 0; end
        end
      end else if (!m_lk) begin
        m_phase = 0; m_age = 0; m_lost = 1'b1;
      end
      if (clear_count) m_count = m_lost ? 1 : 0;
      else if (m_lost) m_count = (m_count >= 255) ? 255 : m_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, output int n);
    n = 0;
    while (state !== s && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; locked_in = 1'b1;
    tick(); tick();
    vectors++;
    if ({pll_rst, sys_reset_n, ready, state, lock_loss_count} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_values got %b req %b", {pll_rst, sys_reset_n, ready, state, lock_loss_count}, {1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
    end
    reset_n = 1'b1;
    wait_state(2'd1, n);
    vectors++;
    if (n !== PR || pll_rst !== 1'b0) begin
      miscompares++; $display("FAIL pll_rst_width got %0d (pll_rst=%b) req %0d", n, pll_rst, PR);
    end
    wait_state(2'd2, n);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL wait_to_stable got %0d req 1", n); end
    wait_state(2'd3, n);
    vectors++;
    if (n !== ST || sys_reset_n !== 1'b1 || ready !== 1'b1 || lock_loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL first_release got %0d sys=%b rdy=%b cnt=%0d req %0d 1 1 0", n, sys_reset_n, ready, lock_loss_count, ST);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    locked_in = 1'b0;
    wait_state(2'd0, n);
    vectors++;
    if (n !== 3 || sys_reset_n !== 1'b0 || pll_rst !== 1'b1 || lock_loss_count !== 8'd1) begin
      miscompares++;
      $display("FAIL loss_latency got %0d sys=%b pll=%b cnt=%0d req 3 0 1 1", n, sys_reset_n, pll_rst, lock_loss_count);
    end
    tick(); tick();
    locked_in = 1'b1;
    wait_state(2'd1, n);
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL loss_pll_rst_pulse got %0d req 2 more", n); end
    wait_state(2'd2, n);
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL loss_relock got %0d req 1", n); end
    wait_state(2'd3, n);
    vectors++;
    if (n !== ST || lock_loss_count !== 8'd1) begin
      miscompares++; $display("FAIL loss_rerelease got %0d cnt=%0d req %0d 1", n, lock_loss_count, ST);
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    force_relock = 1'b1; tick(); force_relock = 1'b0;
    wait_state(2'd1, n);
    vectors++;
    if (n !== PR) begin miscompares++; $display("FAIL force_pll_rst got %0d req %0d", n, PR); end
    wait_state(2'd2, n);
    tick(); tick(); tick();
    locked_in = 1'b0; tick();
    locked_in = 1'b1; tick(); tick();
    vectors++;
    if (state !== 2'd1 || lock_loss_count !== 8'd1) begin
      miscompares++; $display("FAIL glitch_back_to_wait got state=%0d cnt=%0d req 1 1", state, lock_loss_count);
    end
    wait_state(2'd2, n);
    wait_state(2'd3, n);
    vectors++;
    if (n !== ST) begin miscompares++; $display("FAIL glitch_full_window got %0d req %0d", n, ST); end
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    locked_in = 1'b0;
    force_relock = 1'b1; tick(); force_relock = 1'b0;
    wait_state(2'd1, n);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      wait_state(2'd0, n);
      vectors++;
      if (n !== TO || sys_reset_n !== 1'b0) begin
        miscompares++; $display("FAIL timeout_wait got %0d sys=%b req %0d 0", n, sys_reset_n, TO);
      end
      wait_state(2'd1, n);
      vectors++;
      if (n !== PR) begin miscompares++; $display("FAIL timeout_pulse got %0d req %0d", n, PR); end
    end
`else
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (state !== 2'd1 || sys_reset_n !== 1'b0 || pll_rst !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL wait_forever got %0d bad cycles req 0", bad); end
`endif
    locked_in = 1'b1;
    wait_state(2'd3, n);
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL timeout_recover got ready=%b req 1", ready); end
  endtask

  task automatic test_saturation();
    int n;
    for (int k = 0; k < 256; k++) begin
      locked_in = 1'b0; wait_state(2'd0, n);
      locked_in = 1'b1; wait_state(2'd3, n);
    end
    vectors++;
    if (lock_loss_count !== 8'd255) begin
      miscompares++; $display("FAIL saturate got %0d req 255", lock_loss_count);
    end
    locked_in = 1'b0; tick(); tick();
    clear_count = 1'b1; tick(); clear_count = 1'b0;
    vectors++;
    if (lock_loss_count !== 8'd1 || state !== 2'd0) begin
      miscompares++; $display("FAIL clear_with_loss got cnt=%0d state=%0d req 1 0", lock_loss_count, state);
    end
    clear_count = 1'b1; tick(); clear_count = 1'b0;
    vectors++;
    if (lock_loss_count !== 8'd0) begin miscompares++; $display("FAIL clear_alone got %0d req 0", lock_loss_count); end
    locked_in = 1'b1; wait_state(2'd3, n);
  endtask

  task automatic test_force_with_loss();
    int n;
    locked_in = 1'b0; tick(); tick();
    force_relock = 1'b1; tick(); force_relock = 1'b0;
    vectors++;
    if (state !== 2'd0 || pll_rst !== 1'b1 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL force_priority got state=%0d pll=%b rdy=%b cnt=%0d req 0 1 0 0", state, pll_rst, ready, lock_loss_count);
    end
    locked_in = 1'b1; wait_state(2'd3, n);
  endtask

  task automatic test_reset_mid_stable();
    int n;
    force_relock = 1'b1; tick(); force_relock = 1'b0;
    wait_state(2'd2, n);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({pll_rst, sys_reset_n, ready, state, lock_loss_count} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL async_reset got %b req %b", {pll_rst, sys_reset_n, ready, state, lock_loss_count}, {1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
    end
    tick(); reset_n = 1'b1;
    wait_state(2'd3, n);
    vectors++;
    if (n !== PR + 1 + ST) begin miscompares++; $display("FAIL fresh_sequence got %0d req %0d", n, PR + 1 + ST); end
  endtask

  task automatic test_random();
    logic [12:0] expv;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) locked_in = ~locked_in;
      force_relock = ($urandom_range(0, 199) == 0);
      clear_count  = ($urandom_range(0, 99) == 0);
      tick();
      expv = {m_phase == 0, m_phase == 3, m_phase == 3, m_phase[1:0], m_count[7:0]};
      vectors++;
      if ({pll_rst, sys_reset_n, ready, state, lock_loss_count} !== expv) begin
        miscompares++;
        $display("FAIL random_cycle_%0d got %b req %b", k, {pll_rst, sys_reset_n, ready, state, lock_loss_count}, expv);
      end
    end
    force_relock = 1'b0; clear_count = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_loss();
    test_stable_glitch();
    test_timeout();
    test_saturation();
    test_force_with_loss();
    test_reset_mid_stable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout req completion");
    $fatal(1, "watchdog");
  end

endmodule
